// File: rtl/genie_mem_arbiter.sv
// Round-robin owner arbiter for Genie's shared memory port.
// Four layer engines contend; lock and completion quota shape hand-over.
module genie_mem_arbiter #(
  parameter int QUOTA = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [3:0]   req_wvalid,
  input  logic [103:0] req_waddr,
  input  logic [127:0] req_wdata,
  output logic [3:0]   req_wready,
  input  logic [3:0]   req_rvalid,
  input  logic [103:0] req_raddr,
  output logic [3:0]   req_rready,
  output logic [127:0] req_rdata,
  input  logic [3:0]   req_lock,
  output logic         wvalid,
  input  logic         wready,
  output logic [25:0]  waddr,
  output logic [31:0]  wdata,
  output logic         rvalid,
  input  logic         rready,
  output logic [25:0]  raddr,
  input  logic [31:0]  rdata,
  output logic [3:0]   gnt,
  output logic         busy
);

  typedef enum logic {IDLE, OWN} state_e;

  state_e      state_q, state_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [1:0]  last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;

  logic [3:0]  req_any;
  logic [3:0]  others;
  logic [1:0]  own;
  logic        comp;
  logic        at_quota;
  logic        rel;

  // First requester after base, wrapping; base itself is tried last.
  function automatic logic [3:0] rr(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [1:0] idx;
    rr = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) begin
        rr = '0;
        rr[idx] = 1'b1;
      end
    end
  endfunction

  assign req_any  = req_rvalid | req_wvalid;
  assign others   = req_any & ~gnt_q;
  assign comp     = rready | wready;
  assign at_quota = (cnt_q == 8'(QUOTA - 1));

  always_comb begin
    own = 2'd0;
    unique case (1'b1)
      gnt_q[1]: own = 2'd1;
      gnt_q[2]: own = 2'd2;
      gnt_q[3]: own = 2'd3;
      default:  own = 2'd0;
    endcase
  end

  assign rel = !req_lock[own] &&
    (!req_any[own] || (comp && at_quota && |others));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req_any) begin
          gnt_d   = rr(req_any, last_q);
          state_d = OWN;
          cnt_d   = '0;
        end
      end
      OWN: begin
        if (rel) begin
          last_d = own;
          cnt_d  = '0;
          if (|others) begin
            gnt_d = rr(others, own);
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (comp && !at_quota) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    waddr     = '0;
    wdata     = '0;
    raddr     = '0;
    req_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (gnt_q[i]) begin
        waddr = req_waddr[26*i +: 26];
        wdata = req_wdata[32*i +: 32];
        raddr = req_raddr[26*i +: 26];
        req_rdata[32*i +: 32] = rdata;
      end
    end
  end

  assign wvalid     = |(req_wvalid & gnt_q);
  assign rvalid     = |(req_rvalid & gnt_q);
  assign req_wready = gnt_q & {4{wready}};
  assign req_rready = gnt_q & {4{rready}};
  assign gnt        = gnt_q;
  assign busy       = |gnt_q;

endmodule

// File: doc/genie_mem_arbiter.md
# genie_mem_arbiter

Round-robin arbiter that shares Genie's single external memory port (read and write channels) among four layer engines, indexed by layer-type slot 0..3. It replaces the static layer-type multiplexer at the top level and sits between the engines' data loaders and the memory interface. It adds ownership tracking, per-owner lock, a completion quota with fair hand-over, and zero masking of responses to non-owners.

## Interface

Parameters:
- QUOTA, 16: number of completions an unlocked owner may take while others wait (1..255).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_wvalid  in  4  per-engine write request; bit i = engine i
- req_waddr  in  104  engine i address at [26i+25:26i]
- req_wdata  in  128  engine i data at [32i+31:32i]
- req_wready  out  4  write-accept pulse, owner bit only
- req_rvalid  in  4  per-engine read request
- req_raddr  in  104  engine i read address at [26i+25:26i]
- req_rready  out  4  read-data-valid pulse, owner bit only
- req_rdata  out  128  read data; owner slot = mem_rdata, other slots 0
- req_lock  in  4  owner i holds the grant while asserted
- wvalid  out  1  memory write request
- wready  in  1  memory write accept
- waddr  out  26  memory write address
- wdata  out  32  memory write data
- rvalid  out  1  memory read request
- rready  in  1  memory read data valid
- raddr  out  26  memory read address
- rdata  in  32  memory read data
- gnt  out  4  one-hot current owner; 0 when idle
- busy  out  1  = |gnt

## Operation

Channel protocol (both sides):
- A master holds valid and address (and data) stable until the matching ready pulse.
- The ready pulse completes exactly one beat. The master may re-assert on the next cycle.

Ownership:
- An engine requests when req_rvalid[i] | req_wvalid[i].
- Lock alone is not a request.

FSM: IDLE, OWN.
- **IDLE:** if any engine requests, at the next edge grant the first requester searching from last_owner+1 modulo 4, then go to OWN and clear beat_cnt.
- **OWN → release** at an edge when req_lock[owner]=0 and either:
  - (a) the owner is not requesting this cycle, or
  - (b) a completion occurs this cycle, beat_cnt==QUOTA-1, and another engine is requesting.
- **On release:**
  - If another engine is requesting, grant it (round-robin, excluding the old owner) at the same edge, with no idle bubble.
  - Otherwise go to IDLE with gnt=0.
  - last_owner := old owner.
- **On a locked owner:** grant is held regardless of requests or quota. beat_cnt saturates at QUOTA-1.

Muxing:
- Memory outputs are combinational from registered gnt and the owner's inputs. All memory outputs are 0 when gnt=0.
- wready/rready/rdata are routed to the owner slot only. Non-owner ready bits and rdata slots are 0.

Completion accounting:
- completion = rready | wready (owner side).
- Simultaneous rready and wready count as one completion.
- beat_cnt is 8 bits, cleared on every grant change.

Owner read and write in the same cycle: both channels are passed through; the memory resolves them.

## Timing

- Reset values: gnt=0, busy=0, wvalid=0, rvalid=0, waddr=0, raddr=0, wdata=0, req_wready=0, req_rready=0, req_rdata=0, state=IDLE, beat_cnt=0, last_owner=3 (engine 0 has top priority after reset).
- Request-to-memory latency from IDLE: request at cycle t gives gnt and memory valid at cycle t+1.
- Hand-over latency: the new owner's valid appears at the memory the cycle after the release edge.
- The grant never changes while the owner holds an uncompleted valid, except by reset.
- Response path: memory ready/rdata to engine is combinational, 0 cycles.
- Reset mid-transaction: all outputs drop to 0 asynchronously. The in-flight beat is abandoned, and the memory controller must also be reset.
- A request withdrawn by a non-owner before grant is legal and is ignored.

## Test plan

- **Reset:** assert rst_n=0 with random inputs → every output 0, gnt=0. Release → first requester search starts at engine 0.
- **Single read:** engine 1 rvalid, raddr=0x0000100 at t → gnt=4'b0010, rvalid=1, raddr=0x0000100 at t+1. Memory rready with rdata=0xDEADBEEF → req_rready=4'b0010, slot 1 = 0xDEADBEEF, other slots 0.
- **Contention:** engines 0 and 2 request together from reset → engine 0 is granted. After engine 0 drops its request, gnt=4'b0100 at the next edge with no bubble. Engine 0 re-requesting is served after engine 2.
- **Quota:** QUOTA=4; engine 0 issues back-to-back writes, engine 3 pending → exactly 4 wready pulses to engine 0, then gnt=4'b1000 at the edge of the 4th completion.
- **Lock:** same as Quota but req_lock[0]=1 → engine 0 keeps the grant past 10 completions. Lock drops with engine 0 mid-burst → switch to engine 3 at the next completion edge.
- **Async reset mid-beat:** engine 2 rvalid granted, rst_n low before rready → rvalid and gnt go 0 immediately (same cycle).
